mc_control_fsm: RTL and testbench

//  Main control unit for the multicycle RV32I core. Sequences the shared memory port, the

---
 rtl/mc_control_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute and drives every datapath enable.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP and raise illegal_instr.
module mc_control_fsm #(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 mem_req,
`ifdef ILLEGAL_TRAP_EN
    output logic                 illegal_instr,
`endif
    output logic [3:0]           dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b000);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b001);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b010);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b011);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b101);

    state_t state;
    state_t state_next;
    logic [ALUCTRL_W-1:0] alu_dec;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // ALU operation for R/I-type execute; sub only for R-type with funct7b5 set.
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    // Memory handshake: mem_req is held for the whole access; an access completes
    // on a cycle where mem_req and mem_ready are both high, otherwise the FSM stalls.
    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegWrite   = 1'b0;
        ALUControl = ALU_ADD;
        mem_req    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ALUControl = ALU_ADD;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b10;
                ALUControl = ALU_ADD;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BEQ:            state_next = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                if (op == OP_STORE) begin
                    ImmSrc     = 2'b01;
                    state_next = S_MEMWRITE;
                end else begin
                    ImmSrc     = 2'b00;
                    state_next = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = alu_dec;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b00;
                ALUControl = alu_dec;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = 2'b00;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC takes the jump target from ALUOut while the ALU forms OldPC+4 for rd.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b00;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = ALU_SUB;
                ResultSrc  = 2'b00;
                PCWrite    = Zero;
                state_next = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_instr = 1'b1;
                state_next    = S_TRAP;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed literal checks, then random instruction streams
// compared every cycle against an instruction-level model of the control outputs.
module tb_mc_control_fsm;

    localparam int W = 17;

    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_ADR_LD = 2;
    localparam int P_ADR_ST = 3;
    localparam int P_RD     = 4;
    localparam int P_MEMWB  = 5;
    localparam int P_WR     = 6;
    localparam int P_EXR    = 7;
    localparam int P_EXI    = 8;
    localparam int P_ALUWB  = 9;
    localparam int P_JAL    = 10;
    localparam int P_BEQ    = 11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_req;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] dbg_state;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    logic [6:0] cur_op = '0;
    logic [2:0] cur_f3 = '0;
    logic       cur_f7 = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] dut_vec;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.ALUCTRL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
        .mem_req(mem_req),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr(illegal_instr),
`endif
        .dbg_state(dbg_state)
    );

    assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                      ImmSrc, RegWrite, ALUControl, mem_req};

    function automatic logic [2:0] alu_of(logic [6:0] o, logic [2:0] f3, logic f7);
        if (f3 == 3'b000) return (o == OP_RTYPE && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Expected control word for one cycle of an instruction, from the step it is in.
    function automatic logic [W-1:0] model(int ph, logic rdy, logic zr,
                                           logic [6:0] o, logic [2:0] f3, logic f7);
        logic pcw, adr, mw, irw, rw, mr;
        logic [1:0] rs, sa, sb, is;
        logic [2:0] ac;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; mr = 0;
        rs = 0; sa = 0; sb = 0; is = 0; ac = 0;
        case (ph)
            P_FETCH:  begin mr = 1; sb = 2; rs = 2; irw = rdy; pcw = rdy; end
            P_DECODE: begin sa = 1; sb = 1; is = 2; end
            P_ADR_LD: begin sa = 2; sb = 1; end
            P_ADR_ST: begin sa = 2; sb = 1; is = 1; end
            P_RD:     begin mr = 1; adr = 1; end
            P_MEMWB:  begin rs = 1; rw = 1; end
            P_WR:     begin mr = 1; adr = 1; mw = 1; end
            P_EXR:    begin sa = 2; ac = alu_of(o, f3, f7); end
            P_EXI:    begin sa = 2; sb = 1; ac = alu_of(o, f3, f7); end
            P_ALUWB:  begin rw = 1; end
            P_JAL:    begin sa = 1; sb = 2; pcw = 1; end
            P_BEQ:    begin sa = 2; ac = 3'b001; pcw = zr; end
            default:  ;
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, is, rw, ac, mr};
    endfunction

    function automatic bit is_legal(logic [6:0] o);
        return o == OP_LOAD || o == OP_STORE || o == OP_RTYPE || o == OP_ITYPE ||
               o == OP_JAL || o == OP_BEQ;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(string name, int act, int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp_v);
        end
    endtask

    task automatic set_instr(logic [6:0] o, logic [2:0] f3, logic f7);
        cur_op = o; cur_f3 = f3; cur_f7 = f7;
    endtask

    task automatic drive(logic rdy, logic zr);
        @(negedge clk);
        op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
        mem_ready = rdy; Zero = zr;
    endtask

    task automatic dstep(logic rdy, logic zr);
        drive(rdy, zr);
        #3;
    endtask

    task automatic cyc(int ph, logic rdy, logic zr);
        drive(rdy, zr);
        exp_q.push_back(model(ph, rdy, zr, cur_op, cur_f3, cur_f7));
    endtask

    task automatic mem_wait(int ph);
        int mw;
        mw = $urandom_range(0, 3);
        for (int i = 0; i < mw; i++) cyc(ph, 1'b0, rb());
        cyc(ph, 1'b1, rb());
    endtask

    task automatic run_random_instr();
        int cls;
        int fw;
        logic [6:0] o;
`ifdef ILLEGAL_TRAP_EN
        cls = $urandom_range(0, 5);
`else
        cls = $urandom_range(0, 6);
`endif
        case (cls)
            0: o = OP_LOAD;
            1: o = OP_STORE;
            2: o = OP_RTYPE;
            3: o = OP_ITYPE;
            4: o = OP_JAL;
            5: o = OP_BEQ;
            default: begin
                o = 7'($urandom);
                while (is_legal(o)) o = 7'($urandom);
            end
        endcase
        set_instr(o, 3'($urandom), 1'($urandom));
        fw = $urandom_range(0, 2);
        for (int i = 0; i < fw; i++) cyc(P_FETCH, 1'b0, rb());
        cyc(P_FETCH, 1'b1, rb());
        cyc(P_DECODE, rb(), rb());
        case (cls)
            0: begin cyc(P_ADR_LD, rb(), rb()); mem_wait(P_RD); cyc(P_MEMWB, rb(), rb()); end
            1: begin cyc(P_ADR_ST, rb(), rb()); mem_wait(P_WR); end
            2: begin cyc(P_EXR, rb(), rb()); cyc(P_ALUWB, rb(), rb()); end
            3: begin cyc(P_EXI, rb(), rb()); cyc(P_ALUWB, rb(), rb()); end
            4: begin cyc(P_JAL, rb(), rb()); cyc(P_ALUWB, rb(), rb()); end
            5: begin cyc(P_BEQ, rb(), rb()); end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        #3;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (dut_vec !== e) begin
                bad++;
                $display("FAIL cycle_vec: got %b want %b (dbg_state %0d)", dut_vec, e, dbg_state);
            end
        end
    end

    initial begin
        #1_000_000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int wb_cnt;
        int mw_cnt;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_irwrite", int'(IRWrite), 1);
        chk("rst_pcwrite", int'(PCWrite), 1);

        // lw: reset mid-MEMREAD, then a clean lw with no wait states
        set_instr(OP_LOAD, 3'b010, 1'b0);
        @(negedge clk);
        op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7; rst_n = 1'b1; mem_ready = 1'b1;
        #3;
        dstep(1'b1, 1'b0);
        dstep(1'b1, 1'b0);
        dstep(1'b0, 1'b0);
        chk("memread_adrsrc", int'(AdrSrc), 1);
        chk("memread_req", int'(mem_req), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_adrsrc", int'(AdrSrc), 0);
        chk("async_rst_alusrcb", int'(ALUSrcB), 2);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        #3;
        chk("rel_irwrite", int'(IRWrite), 1);
        chk("rel_pcwrite", int'(PCWrite), 1);
        wb_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) dstep(1'b1, 1'b0);
            chk($sformatf("lw_wb_c%0d", k), int'(RegWrite && ResultSrc == 2'b01), int'(k == 5));
            if (k == 4) chk("lw_c4_adrsrc", int'(AdrSrc), 1);
        end

        // sw with three wait states
        set_instr(OP_STORE, 3'b010, 1'b0);
        dstep(1'b1, 1'b0);
        dstep(1'b1, 1'b0);
        dstep(1'b1, 1'b0);
        chk("sw_immsrc", int'(ImmSrc), 1);
        mw_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            dstep(i == 3, 1'b0);
            mw_cnt += int'(MemWrite);
        end
        chk("sw_memwrite_cycles", mw_cnt, 4);

        // sub then addi with the same funct fields
        set_instr(OP_RTYPE, 3'b000, 1'b1);
        dstep(1'b1, 1'b0);
        chk("sw_back_fetch", int'(IRWrite && !MemWrite), 1);
        dstep(1'b1, 1'b0);
        dstep(1'b1, 1'b0);
        chk("sub_aluctrl", int'(ALUControl), 1);
        dstep(1'b1, 1'b0);
        chk("alu_wb_regwrite", int'(RegWrite), 1);
        set_instr(OP_ITYPE, 3'b000, 1'b1);
        dstep(1'b1, 1'b0);
        dstep(1'b1, 1'b0);
        dstep(1'b1, 1'b0);
        chk("addi_aluctrl", int'(ALUControl), 0);
        chk("addi_alusrcb", int'(ALUSrcB), 1);
        dstep(1'b1, 1'b0);

        // beq taken and not taken
        set_instr(OP_BEQ, 3'b000, 1'b0);
        dstep(1'b1, 1'b0);
        dstep(1'b1, 1'b0);
        dstep(1'b1, 1'b1);
        chk("beq_taken_pcwrite", int'(PCWrite), 1);
        chk("beq_aluctrl", int'(ALUControl), 1);
        dstep(1'b1, 1'b0);
        chk("beq_3cyc_fetch", int'(IRWrite), 1);
        dstep(1'b1, 1'b1);
        dstep(1'b1, 1'b0);
        chk("beq_not_taken_pcwrite", int'(PCWrite), 0);

        // unknown opcode
        set_instr(7'b1111111, 3'b000, 1'b0);
        dstep(1'b1, 1'b0);
        chk("beq_nt_back_fetch", int'(IRWrite), 1);
        dstep(1'b1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        dstep(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("trap_illegal_%0d", i), int'(illegal_instr), 1);
            chk($sformatf("trap_outs_%0d", i), int'(dut_vec), 0);
            dstep(1'b1, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("trap_reset_illegal", int'(illegal_instr), 0);
`else
        dstep(1'b0, 1'b0);
        chk("illegal_to_fetch_req", int'(mem_req), 1);
        chk("illegal_to_fetch_alusrcb", int'(ALUSrcB), 2);
`endif

        repeat (300) run_random_instr();
        repeat (2) @(negedge clk);
        #5;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
